// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath controls, and traps on illegal opcodes or memory watchdog expiry.
//
// state     | meaning
// ----------+-------------------------------------------
// FETCH     | read instruction at PC, PC += 4 on ready
// DECODE    | register read, branch target into ALUOut
// MEM_ADDR  | effective address A + sign-ext imm
// MEM_RD    | load data read, waits for mem_ready
// MEM_WB    | load data written to rt
// MEM_WR    | store, waits for mem_ready
// R_EXEC    | R-type ALU operation
// R_WB      | R-type result written to rd
// BRANCH    | beq compare, PC <= ALUOut when equal
// JUMP      | PC <= jump target
// I_EXEC    | immediate ALU operation (addiu/ori/lui)
// I_WB      | immediate result written to rt
// TRAP      | dead until reset
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter bit EN_LUI  = 1'b0,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [RET_W-1:0] retired,
  output logic             illegal,
  output logic             timeout
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            WD_EN   = (TIMEOUT > 0);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] wcnt;
  logic          wd_hit;
  logic          wait_st;
  logic          set_illegal;
  logic          set_timeout;

  assign state   = cur;
  assign wait_st = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  assign wd_hit  = WD_EN && !mem_ready && (wcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      wcnt    <= '0;
      retired <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cur <= nxt;
      // counter restarts on every state change, so entry to a wait state sees 0
      if (nxt != cur)
        wcnt <= '0;
      else if (wait_st && !mem_ready)
        wcnt <= wcnt + 1'b1;
      if (instr_done)
        retired <= retired + 1'b1;
      if (set_illegal)
        illegal <= 1'b1;
      if (set_timeout)
        timeout <= 1'b1;
    end
  end

  always_comb begin
    nxt         = cur;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_source   = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    ext_op      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    instr_done  = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          nxt = S_DECODE;
        end else if (wd_hit) begin
          nxt         = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW:      nxt = S_MEM_ADDR;
          OP_RTYPE:          nxt = S_R_EXEC;
          OP_BEQ:            nxt = S_BRANCH;
          OP_J:              nxt = S_JUMP;
          OP_ORI, OP_ADDIU:  nxt = S_I_EXEC;
          OP_LUI: begin
            if (EN_LUI) begin
              nxt = S_I_EXEC;
            end else begin
              nxt         = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          default: begin
            nxt         = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          nxt = S_MEM_WB;
        end else if (wd_hit) begin
          nxt         = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = S_FETCH;
        end else if (wd_hit) begin
          nxt         = S_TRAP;
          set_timeout = 1'b1;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        nxt       = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_b = 2'b10;
        nxt       = S_I_WB;
        case (op)
          OP_ORI: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b011;
            ext_op    = 2'b01;
          end
          OP_LUI: begin
            alu_op = 3'b100;
            ext_op = 2'b10;
          end
          default: begin
            alu_src_a = 1'b1;
          end
        endcase
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt        = S_FETCH;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        nxt = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors are queued by
// the stimulus and compared by an independent negedge monitor.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source, alu_src_a,
  //  alu_src_b, alu_op, ext_op, reg_write, reg_dst, mem_to_reg}
  localparam logic [17:0] C_FETCH0  = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_FETCH1  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MRD     = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_MWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0,1'b1};
  localparam logic [17:0] C_MWR     = {1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_REXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,3'b010,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b1,1'b0};
  localparam logic [17:0] C_BR1     = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,3'b001,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_BR0     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,3'b001,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_JUMP    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_IEX_LUI = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,3'b100,2'b10,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_IEX_ORI = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b011,2'b01,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_IEX_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,3'b000,2'b00,1'b0,1'b0,1'b0};
  localparam logic [17:0] C_IWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,2'b00,1'b1,1'b0,1'b0};
  localparam logic [17:0] C_ZERO    = 18'd0;

  typedef struct {
    string       nm;
    bit          which;
    logic [3:0]  st;
    logic [17:0] ctrl;
    logic        done;
    logic [31:0] ret;
    logic        il;
    logic        to;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  logic zero = 1'b0;
  logic rst1 = 1'b1, rdy1 = 1'b0;
  logic rst2 = 1'b1, rdy2 = 1'b0;
  logic [5:0] op1 = 6'd0, op2 = 6'd0;

  always #5 clk = ~clk;

  logic mr1, mw1, iod1, irw1, pcw1, asa1, rw1, rd1, m2r1, dn1, il1, to1;
  logic [1:0] pcs1, asb1, ext1;
  logic [2:0] aop1;
  logic [3:0] st1;
  logic [31:0] ret1;
  logic mr2, mw2, iod2, irw2, pcw2, asa2, rw2, rd2, m2r2, dn2, il2, to2;
  logic [1:0] pcs2, asb2, ext2;
  logic [2:0] aop2;
  logic [3:0] st2;
  logic [31:0] ret2;

  multicycle_ctrl #(.TIMEOUT(4), .EN_LUI(1'b0), .RET_W(32)) dut (
    .clk(clk), .rst(rst1), .op(op1), .zero(zero), .mem_ready(rdy1),
    .mem_read(mr1), .mem_write(mw1), .i_or_d(iod1), .ir_write(irw1),
    .pc_write(pcw1), .pc_source(pcs1), .alu_src_a(asa1), .alu_src_b(asb1),
    .alu_op(aop1), .ext_op(ext1), .reg_write(rw1), .reg_dst(rd1),
    .mem_to_reg(m2r1), .state(st1), .instr_done(dn1), .retired(ret1),
    .illegal(il1), .timeout(to1)
  );

  multicycle_ctrl #(.TIMEOUT(15), .EN_LUI(1'b1), .RET_W(32)) dut_lui (
    .clk(clk), .rst(rst2), .op(op2), .zero(zero), .mem_ready(rdy2),
    .mem_read(mr2), .mem_write(mw2), .i_or_d(iod2), .ir_write(irw2),
    .pc_write(pcw2), .pc_source(pcs2), .alu_src_a(asa2), .alu_src_b(asb2),
    .alu_op(aop2), .ext_op(ext2), .reg_write(rw2), .reg_dst(rd2),
    .mem_to_reg(m2r2), .state(st2), .instr_done(dn2), .retired(ret2),
    .illegal(il2), .timeout(to2)
  );

  wire [17:0] act1 = {mr1, mw1, iod1, irw1, pcw1, pcs1, asa1, asb1, aop1, ext1, rw1, rd1, m2r1};
  wire [17:0] act2 = {mr2, mw2, iod2, irw2, pcw2, pcs2, asa2, asb2, aop2, ext2, rw2, rd2, m2r2};

  // monitor: one queued vector per cycle, checked mid-cycle
  always @(negedge clk) begin : monitor
    rec_t        r;
    logic [56:0] act, exp;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (!r.which) act = {st1, act1, dn1, ret1, il1, to1};
      else          act = {st2, act2, dn2, ret2, il2, to2};
      exp = {r.st, r.ctrl, r.done, r.ret, r.il, r.to};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got st=%0d ctrl=%b done=%b ret=%0d il=%b to=%b, want st=%0d ctrl=%b done=%b ret=%0d il=%b to=%b",
                 r.nm, act[56:53], act[52:35], act[34], act[33:2], act[1], act[0],
                 r.st, r.ctrl, r.done, r.ret, r.il, r.to);
      end
    end
  end

  task automatic cyc(input bit w, input logic rdy, input logic [5:0] o, input logic z,
                     input logic [3:0] s, input logic [17:0] c, input logic dn,
                     input int ret, input logic il, input logic to, input string nm);
    rec_t r;
    @(posedge clk); #1;
    if (!w) begin rst1 = 1'b0; rdy1 = rdy; op1 = o; end
    else    begin rst2 = 1'b0; rdy2 = rdy; op2 = o; end
    zero = z;
    r.nm = nm; r.which = w; r.st = s; r.ctrl = c; r.done = dn;
    r.ret = ret; r.il = il; r.to = to;
    q.push_back(r);
  endtask

  task automatic rst_pulse(input bit w);
    @(posedge clk); #1;
    if (!w) rst1 = 1'b1; else rst2 = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    cyc(0, 0, OP_LW,  0, 0, C_FETCH0, 0, 0, 0, 0, "reset");
    // lw, zero-wait
    cyc(0, 1, OP_LW,  0, 0, C_FETCH1, 0, 0, 0, 0, "lw_fetch");
    cyc(0, 1, OP_LW,  0, 1, C_DECODE, 0, 0, 0, 0, "lw_decode");
    cyc(0, 1, OP_LW,  0, 2, C_MADDR,  0, 0, 0, 0, "lw_maddr");
    cyc(0, 1, OP_LW,  0, 3, C_MRD,    0, 0, 0, 0, "lw_mrd");
    cyc(0, 1, OP_LW,  0, 4, C_MWB,    1, 0, 0, 0, "lw_mwb");
    // beq taken / not taken
    cyc(0, 1, OP_BEQ, 1, 0, C_FETCH1, 0, 1, 0, 0, "beq1_fetch");
    cyc(0, 1, OP_BEQ, 1, 1, C_DECODE, 0, 1, 0, 0, "beq1_decode");
    cyc(0, 1, OP_BEQ, 1, 8, C_BR1,    1, 1, 0, 0, "beq1_branch");
    cyc(0, 1, OP_BEQ, 0, 0, C_FETCH1, 0, 2, 0, 0, "beq0_fetch");
    cyc(0, 1, OP_BEQ, 0, 1, C_DECODE, 0, 2, 0, 0, "beq0_decode");
    cyc(0, 1, OP_BEQ, 0, 8, C_BR0,    1, 2, 0, 0, "beq0_branch");
    // sw with three not-ready cycles
    cyc(0, 1, OP_SW,  0, 0, C_FETCH1, 0, 3, 0, 0, "sw_fetch");
    cyc(0, 1, OP_SW,  0, 1, C_DECODE, 0, 3, 0, 0, "sw_decode");
    cyc(0, 1, OP_SW,  0, 2, C_MADDR,  0, 3, 0, 0, "sw_maddr");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, OP_SW, 0, 5, C_MWR,   0, 3, 0, 0, "sw_wait");
    cyc(0, 1, OP_SW,  0, 5, C_MWR,    1, 3, 0, 0, "sw_ready");
    // R-type
    cyc(0, 1, OP_R,   0, 0, C_FETCH1, 0, 4, 0, 0, "r_fetch");
    cyc(0, 1, OP_R,   0, 1, C_DECODE, 0, 4, 0, 0, "r_decode");
    cyc(0, 1, OP_R,   0, 6, C_REXEC,  0, 4, 0, 0, "r_exec");
    cyc(0, 1, OP_R,   0, 7, C_RWB,    1, 4, 0, 0, "r_wb");
    // j
    cyc(0, 1, OP_J,   0, 0, C_FETCH1, 0, 5, 0, 0, "j_fetch");
    cyc(0, 1, OP_J,   0, 1, C_DECODE, 0, 5, 0, 0, "j_decode");
    cyc(0, 1, OP_J,   0, 9, C_JUMP,   1, 5, 0, 0, "j_jump");
    // ready on the 4th wait cycle beats the watchdog
    for (int i = 0; i < 3; i++)
      cyc(0, 0, OP_J, 0, 0, C_FETCH0, 0, 6, 0, 0, "wd_wait");
    cyc(0, 1, OP_J,   0, 0, C_FETCH1, 0, 6, 0, 0, "wd_late_ready");
    cyc(0, 1, OP_J,   0, 1, C_DECODE, 0, 6, 0, 0, "wd_decode");
    cyc(0, 1, OP_J,   0, 9, C_JUMP,   1, 6, 0, 0, "wd_jump");
    // stuck memory: four wait cycles then TRAP
    for (int i = 0; i < 4; i++)
      cyc(0, 0, OP_J, 0, 0, C_FETCH0, 0, 7, 0, 0, "to_wait");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, OP_J, 0, 12, C_ZERO,  0, 7, 0, 1, "to_trap");
    rst_pulse(0);
    cyc(0, 1, OP_LUI, 0, 0, C_FETCH1, 0, 0, 0, 0, "trap_reset");
    // lui illegal without EN_LUI
    cyc(0, 1, OP_LUI, 0, 1, C_DECODE, 0, 0, 0, 0, "ill_decode");
    for (int i = 0; i < 20; i++)
      cyc(0, 1, OP_LUI, 1, 12, C_ZERO, 0, 0, 1, 0, "ill_trap");
    // reset mid-wait abandons the load
    rst_pulse(0);
    cyc(0, 1, OP_LW,  0, 0, C_FETCH1, 0, 0, 0, 0, "mid_fetch");
    cyc(0, 1, OP_LW,  0, 1, C_DECODE, 0, 0, 0, 0, "mid_decode");
    cyc(0, 1, OP_LW,  0, 2, C_MADDR,  0, 0, 0, 0, "mid_maddr");
    cyc(0, 0, OP_LW,  0, 3, C_MRD,    0, 0, 0, 0, "mid_mrd");
    rst_pulse(0);
    cyc(0, 0, OP_LW,  0, 0, C_FETCH0, 0, 0, 0, 0, "mid_after_rst");
    // EN_LUI instance: lui, ori, addiu
    cyc(1, 1, OP_LUI,   0, 0,  C_FETCH1,  0, 0, 0, 0, "lui_fetch");
    cyc(1, 1, OP_LUI,   0, 1,  C_DECODE,  0, 0, 0, 0, "lui_decode");
    cyc(1, 1, OP_LUI,   0, 10, C_IEX_LUI, 0, 0, 0, 0, "lui_exec");
    cyc(1, 1, OP_LUI,   0, 11, C_IWB,     1, 0, 0, 0, "lui_wb");
    cyc(1, 1, OP_ORI,   0, 0,  C_FETCH1,  0, 1, 0, 0, "ori_fetch");
    cyc(1, 1, OP_ORI,   0, 1,  C_DECODE,  0, 1, 0, 0, "ori_decode");
    cyc(1, 1, OP_ORI,   0, 10, C_IEX_ORI, 0, 1, 0, 0, "ori_exec");
    cyc(1, 1, OP_ORI,   0, 11, C_IWB,     1, 1, 0, 0, "ori_wb");
    cyc(1, 1, OP_ADDIU, 0, 0,  C_FETCH1,  0, 2, 0, 0, "addiu_fetch");
    cyc(1, 1, OP_ADDIU, 0, 1,  C_DECODE,  0, 2, 0, 0, "addiu_decode");
    cyc(1, 1, OP_ADDIU, 0, 10, C_IEX_ADD, 0, 2, 0, 0, "addiu_exec");
    cyc(1, 1, OP_ADDIU, 0, 11, C_IWB,     1, 2, 0, 0, "addiu_wb");
    cyc(1, 0, OP_ADDIU, 0, 0,  C_FETCH0,  0, 3, 0, 0, "lui_dut_final");
    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle MIPS control unit, the successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath control lines. Memory accesses use a variable-latency ready handshake with a watchdog timeout. The unit traps on illegal opcodes, and an optional mode adds `lui`.

## Interface
Parameters:
- TIMEOUT, 15: maximum consecutive not-ready cycles in a memory wait state. 0 disables the watchdog.
- EN_LUI, 0: 1 accepts `lui` (op 001111). 0 treats it as illegal.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  the single clock
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode from IR; stable while IR is not written
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_read / mem_write  out  1  memory request; held until mem_ready
- i_or_d  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_op  out  3  000 add, 001 sub, 010 funct-decoded, 011 or, 100 pass B
- ext_op  out  2  00 sign, 01 zero, 10 imm<<16
- reg_write, reg_dst, mem_to_reg  out  1  register file write controls
- state  out  4  current state encoding
- instr_done  out  1  one-cycle retire pulse
- retired  out  RET_W  retired-instruction count; wraps
- illegal, timeout  out  1  sticky trap causes

## Operation
- Reset: state = FETCH, wait counter = 0, retired = 0, illegal = 0, timeout = 0.
- All outputs not listed for a state are 0. Outputs decode combinationally from the state, plus `mem_ready` and `zero` where noted.

State encoding and behaviour:
- FETCH (0): mem_read, alu_src_b = 01, alu_op = add.
  - ir_write = pc_write = mem_ready.
  - mem_ready → DECODE.
- DECODE (1): alu_src_b = 11, alu_op = add. Next state by op:
  - lw/sw → MEM_ADDR.
  - R-type (000000) → R_EXEC.
  - beq → BRANCH.
  - j → JUMP.
  - ori/addiu/lui (when EN_LUI=1) → I_EXEC.
  - anything else → TRAP with illegal = 1.
- MEM_ADDR (2): alu_src_a = 1, alu_src_b = 10, add. lw → MEM_RD, sw → MEM_WR.
- MEM_RD (3): mem_read, i_or_d = 1. mem_ready → MEM_WB.
- MEM_WB (4): reg_write, mem_to_reg = 1. → FETCH, retire.
- MEM_WR (5): mem_write, i_or_d = 1. mem_ready → FETCH, retire.
- R_EXEC (6): alu_src_a = 1, alu_src_b = 00, alu_op = 010. → R_WB.
- R_WB (7): reg_write, reg_dst = 1. → FETCH, retire.
- BRANCH (8): alu_src_a = 1, alu_op = sub, pc_source = 01, pc_write = zero. → FETCH, retire.
- JUMP (9): pc_source = 10, pc_write = 1. → FETCH, retire.
- I_EXEC (10): alu_src_b = 10. → I_WB.
  - addiu: alu_src_a = 1, add, ext 00.
  - ori: alu_src_a = 1, or, ext 01.
  - lui: pass B, ext 10.
- I_WB (11): reg_write, reg_dst = 0. → FETCH, retire.
- TRAP (12): all controls 0; held until rst.
  - illegal/timeout remain set.
  - no further retire.

Retire and watchdog:
- Retire means instr_done = 1 for that cycle and retired += 1 (modulo 2^RET_W).
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each cycle in those states with mem_ready = 0.
  - If mem_ready = 0 and the counter equals TIMEOUT−1 (TIMEOUT > 0), next state is TRAP with timeout = 1.
  - mem_ready = 1 on that same cycle wins (normal transition).

## Timing
- Cycles per instruction with a zero-wait memory (mem_ready = 1 on the request cycle):
  - lw 5
  - sw 4
  - R-type, ori, addiu, lui 4
  - beq 3
  - j 3
- Each not-ready cycle adds one cycle and holds all outputs unchanged.
- TIMEOUT = 4 with mem_ready stuck at 0: 4 cycles in the wait state, TRAP on the 5th.
- rst mid-wait abandons the access. The cycle after rst deasserts is FETCH with mem_read = 1 and retired = 0.
- op is sampled only in DECODE, MEM_ADDR and I_EXEC.

## Test plan
- Reset, then lw with mem_ready always 1 → state 0,1,2,3,4,0. Exactly one instr_done in state 4; retired = 1.
- beq with zero = 1, then with zero = 0 → pc_write = 1 with pc_source = 01 in BRANCH only when zero = 1. Both cycles retire.
- sw with mem_ready delayed 3 cycles in MEM_WR → mem_write held 4 cycles. Retire on the ready cycle; total 7 cycles.
- op = 001111 with EN_LUI = 0 → TRAP; illegal = 1; no retire; stays in TRAP for 20 cycles.
- Same op with EN_LUI = 1 → I_EXEC with alu_op = 100, ext_op = 10, then I_WB with reg_write.
- TIMEOUT = 4, mem_ready = 0 in FETCH → TRAP on cycle 5 with timeout = 1. Repeat with mem_ready = 1 on cycle 4 → DECODE. Assert rst in TRAP → FETCH with flags cleared.
